// File: rtl/cci_mpf_prim_rob_arb_if.sv
// rtl/cci_mpf_prim_rob_arb_if.sv - request, ROB allocate/drain and response signals of the ROB arbiter
// slave is the arbiter side; master is the requester/ROB side.
interface cci_mpf_prim_rob_arb_if #(
  parameter int N_ENTRIES           = 32,
  parameter int MAX_ALLOC_PER_CYCLE = 4
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int LEN_W = $clog2(MAX_ALLOC_PER_CYCLE) + 1;
  localparam int CNT_W = IDX_W + 1;

  logic [1:0]       req_valid;
  logic [LEN_W-1:0] req_len [2];
  logic [1:0]       req_grant;
  logic [IDX_W-1:0] grantIdx;

  logic [LEN_W-1:0] rob_alloc;
  logic             rob_allocMeta;
  logic             rob_notFull;
  logic [IDX_W-1:0] rob_allocIdx;

  logic             rob_notEmpty;
  logic             rob_deq_en;
  logic             rob_T2_firstMeta;

  logic [1:0]       rsp_valid;
  logic [CNT_W-1:0] outstanding [2];

  modport slave (
    input  req_valid, req_len, rob_notFull, rob_allocIdx, rob_notEmpty, rob_T2_firstMeta,
    output req_grant, grantIdx, rob_alloc, rob_allocMeta, rob_deq_en, rsp_valid, outstanding
  );

  modport master (
    output req_valid, req_len, rob_notFull, rob_allocIdx, rob_notEmpty, rob_T2_firstMeta,
    input  req_grant, grantIdx, rob_alloc, rob_allocMeta, rob_deq_en, rsp_valid, outstanding
  );
endinterface

// File: rtl/cci_mpf_prim_rob_arb.sv
// rtl/cci_mpf_prim_rob_arb.sv - two-requester round-robin arbiter for a shared ROB with per-requester line tracking
// Define CCI_MPF_ROB_ARB_QUOTA_EN to cap each requester's outstanding lines at QUOTA.
module cci_mpf_prim_rob_arb #(
  parameter int N_ENTRIES           = 32,
  parameter int MAX_ALLOC_PER_CYCLE = 4,
  parameter int QUOTA               = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  cci_mpf_prim_rob_arb_if.slave    arb
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int LEN_W = $clog2(MAX_ALLOC_PER_CYCLE) + 1;
  localparam int CNT_W = IDX_W + 1;

  logic             prio;
  logic             deq_q;
  logic             deq_qq;
  logic [CNT_W-1:0] out_cnt [2];
  logic [1:0]       qual;
  logic [1:0]       quota_ok;
  logic [1:0]       grant;
  logic [1:0]       rsp;
  logic [CNT_W:0]   inc_sum [2];
  logic [CNT_W-1:0] add_len [2];

  always_comb begin
    for (int r = 0; r < 2; r++) begin
`ifdef CCI_MPF_ROB_ARB_QUOTA_EN
      // One extra bit so a nearly-full counter plus a max-length request cannot wrap.
      quota_ok[r] = (({1'b0, out_cnt[r]} + (CNT_W+1)'(arb.req_len[r])) <= (CNT_W+1)'(QUOTA));
`else
      quota_ok[r] = 1'b1;
`endif
      qual[r] = arb.req_valid[r] && (arb.req_len[r] != '0) &&
                (arb.req_len[r] <= LEN_W'(MAX_ALLOC_PER_CYCLE)) &&
                arb.rob_notFull && !reset && quota_ok[r];
    end

    grant = 2'b00;
    if (qual[prio])
      grant[prio] = 1'b1;
    else if (qual[~prio])
      grant[~prio] = 1'b1;
  end

  assign arb.req_grant     = grant;
  assign arb.rob_alloc     = (grant != 2'b00) ? arb.req_len[grant[1]] : '0;
  assign arb.rob_allocMeta = grant[1];
  assign arb.grantIdx      = arb.rob_allocIdx;
  assign arb.rob_deq_en    = arb.rob_notEmpty & ~reset;

  // The ROB presents the dequeued entry's metadata two cycles after deq_en.
  assign rsp[0]        = deq_qq & ~reset & ~arb.rob_T2_firstMeta;
  assign rsp[1]        = deq_qq & ~reset &  arb.rob_T2_firstMeta;
  assign arb.rsp_valid = rsp;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      add_len[r]        = grant[r] ? CNT_W'(arb.req_len[r]) : '0;
      inc_sum[r]        = {1'b0, out_cnt[r]} + {1'b0, add_len[r]};
      arb.outstanding[r] = out_cnt[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio   <= 1'b0;
      deq_q  <= 1'b0;
      deq_qq <= 1'b0;
      for (int r = 0; r < 2; r++)
        out_cnt[r] <= '0;
    end else begin
      if (grant != 2'b00)
        prio <= ~grant[1];
      deq_q  <= arb.rob_deq_en;
      deq_qq <= deq_q;
      for (int r = 0; r < 2; r++)
        out_cnt[r] <= out_cnt[r] + add_len[r] - CNT_W'(rsp[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 2; r++) begin
        assert (inc_sum[r] >= (CNT_W+1)'(rsp[r]));
        assert ((inc_sum[r] - (CNT_W+1)'(rsp[r])) <= (CNT_W+1)'(N_ENTRIES));
      end
    end
  end
endmodule

// File: tb/tb_cci_mpf_prim_rob_arb.sv
// tb/tb_cci_mpf_prim_rob_arb.sv - directed scoreboard bench for cci_mpf_prim_rob_arb
module tb_cci_mpf_prim_rob_arb;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cci_mpf_prim_rob_arb_if bus ();

  cci_mpf_prim_rob_arb dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the registered state seen by the bench.
  int   m_out [2] = '{0, 0};
  bit   m_deq_q  = 1'b0;
  bit   m_deq_qq = 1'b0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h, required an expectation entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cycle(input bit rst, input logic [1:0] v, input int l0, input int l1,
                       input bit nf, input int aidx, input bit ne, input bit meta,
                       input logic [1:0] g, input string tag);
    int exp_alloc;
    int exp_rsp;
    bit exp_deq;
    reset                = rst;
    bus.req_valid        = v;
    bus.req_len[0]       = 3'(l0);
    bus.req_len[1]       = 3'(l1);
    bus.rob_notFull      = nf;
    bus.rob_allocIdx     = 5'(aidx);
    bus.rob_notEmpty     = ne;
    bus.rob_T2_firstMeta = meta;

    exp_alloc = g[0] ? l0 : (g[1] ? l1 : 0);
    exp_rsp   = (m_deq_qq && !rst) ? (meta ? 2 : 1) : 0;
    exp_deq   = ne & ~rst;

    push_exp({tag, "_grant"}, 32'(g));
    push_exp({tag, "_alloc"}, 32'(exp_alloc));
    if (g != 2'b00) push_exp({tag, "_meta"}, 32'(g[1]));
    push_exp({tag, "_grantIdx"}, 32'(aidx));
    push_exp({tag, "_deq_en"}, 32'(exp_deq));
    push_exp({tag, "_rsp"}, 32'(exp_rsp));
    push_exp({tag, "_out0"}, 32'(m_out[0]));
    push_exp({tag, "_out1"}, 32'(m_out[1]));

    #1;
    pop_chk(32'(bus.req_grant));
    pop_chk(32'(bus.rob_alloc));
    if (g != 2'b00) pop_chk(32'(bus.rob_allocMeta));
    pop_chk(32'(bus.grantIdx));
    pop_chk(32'(bus.rob_deq_en));
    pop_chk(32'(bus.rsp_valid));
    pop_chk(32'(bus.outstanding[0]));
    pop_chk(32'(bus.outstanding[1]));

    @(posedge clk);
    if (rst) begin
      m_out[0] = 0;
      m_out[1] = 0;
      m_deq_q  = 1'b0;
      m_deq_qq = 1'b0;
    end else begin
      m_out[0] = m_out[0] + (g[0] ? l0 : 0) - ((exp_rsp == 1) ? 1 : 0);
      m_out[1] = m_out[1] + (g[1] ? l1 : 0) - ((exp_rsp == 2) ? 1 : 0);
      m_deq_qq = m_deq_q;
      m_deq_q  = exp_deq;
    end
    #1;
  endtask

  initial begin
    reset                = 1'b1;
    bus.req_valid        = 2'b00;
    bus.req_len[0]       = '0;
    bus.req_len[1]       = '0;
    bus.rob_notFull      = 1'b0;
    bus.rob_allocIdx     = '0;
    bus.rob_notEmpty     = 1'b0;
    bus.rob_T2_firstMeta = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs held quiet while reset is high, even with live requests.
    cycle(1, 2'b11, 1, 1, 1, 0, 1, 0, 2'b00, "in_reset");

    // Round-robin alternation with len 1.
    cycle(0, 2'b11, 1, 1, 1, 0, 0, 0, 2'b01, "rr0");
    cycle(0, 2'b11, 1, 1, 1, 1, 0, 0, 2'b10, "rr1");
    cycle(0, 2'b11, 1, 1, 1, 2, 0, 0, 2'b01, "rr2");
    cycle(0, 2'b11, 1, 1, 1, 3, 0, 0, 2'b10, "rr3");

    // ROB full blocks grants; priority is left where it was.
    cycle(0, 2'b11, 1, 1, 0, 4, 0, 0, 2'b00, "notfull0");

    // Grant r1 len 3 while dequeuing one entry that belongs to r1.
    cycle(0, 2'b10, 1, 3, 1, 4, 1, 0, 2'b10, "r1_len3");
    cycle(0, 2'b01, 0, 1, 1, 7, 0, 0, 2'b00, "len0");
    // Response for r1 lands together with a len-2 grant to r1: 5 -> 6.
    cycle(0, 2'b10, 0, 2, 1, 7, 0, 1, 2'b10, "net_grant_rsp");
    cycle(0, 2'b10, 0, 5, 1, 8, 0, 1, 2'b00, "len_over_max");

    // Fill the dequeue pipeline, leave prio at 1, then reset mid-flight.
    cycle(0, 2'b10, 0, 1, 1, 9, 1, 0, 2'b10, "pre_rst_g1");
    cycle(0, 2'b01, 1, 0, 1, 10, 1, 0, 2'b01, "pre_rst_g2");
    cycle(1, 2'b11, 1, 1, 1, 0, 1, 1, 2'b00, "mid_reset");
    cycle(0, 2'b00, 1, 1, 1, 0, 0, 1, 2'b00, "post_rst1");
    cycle(0, 2'b11, 1, 1, 1, 0, 0, 1, 2'b01, "post_rst_prio");

    // Quota scenario from a clean start.
    cycle(1, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, "rst2");
    for (int k = 0; k < 4; k++)
      cycle(0, 2'b01, 4, 0, 1, k * 4, 0, 0, 2'b01, "quota_fill");
`ifdef CCI_MPF_ROB_ARB_QUOTA_EN
    cycle(0, 2'b01, 4, 0, 1, 16, 0, 0, 2'b00, "quota_fifth");
`else
    cycle(0, 2'b01, 4, 0, 1, 16, 0, 0, 2'b01, "quota_fifth");
`endif
    cycle(0, 2'b00, 0, 0, 1, 20, 0, 0, 2'b00, "quota_end");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
